// File: rtl/exec_stage_pkg.sv
// Shared micro-op encodings, widths and flag layout for the execute stage.
package exec_stage_pkg;

    localparam int REG_W      = 64;
    localparam int IMM_W      = 32;
    localparam int RADDR_W    = 4;
    localparam int OPCODE_W   = 5;
    localparam int BIT_MODE_W = 2;

    localparam logic [OPCODE_W-1:0] MICRO_MOV  = 5'd0;
    localparam logic [OPCODE_W-1:0] MICRO_MOVI = 5'd1;
    localparam logic [OPCODE_W-1:0] MICRO_LEA  = 5'd2;
    localparam logic [OPCODE_W-1:0] MICRO_ADD  = 5'd3;
    localparam logic [OPCODE_W-1:0] MICRO_ADDI = 5'd4;
    localparam logic [OPCODE_W-1:0] MICRO_SUB  = 5'd5;
    localparam logic [OPCODE_W-1:0] MICRO_SUBI = 5'd6;
    localparam logic [OPCODE_W-1:0] MICRO_AND  = 5'd7;
    localparam logic [OPCODE_W-1:0] MICRO_ANDI = 5'd8;
    localparam logic [OPCODE_W-1:0] MICRO_OR   = 5'd9;
    localparam logic [OPCODE_W-1:0] MICRO_ORI  = 5'd10;
    localparam logic [OPCODE_W-1:0] MICRO_XOR  = 5'd11;
    localparam logic [OPCODE_W-1:0] MICRO_XORI = 5'd12;
    localparam logic [OPCODE_W-1:0] MICRO_SLLI = 5'd13;

    localparam logic [BIT_MODE_W-1:0] BIT_MODE_8  = 2'd0;
    localparam logic [BIT_MODE_W-1:0] BIT_MODE_16 = 2'd1;
    localparam logic [BIT_MODE_W-1:0] BIT_MODE_32 = 2'd2;
    localparam logic [BIT_MODE_W-1:0] BIT_MODE_64 = 2'd3;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 3;
    localparam int FLAG_OF = 4;

    // Field order puts CF at bit 0 so the packed value matches the FLAG_* indices.
    typedef struct packed {
        logic of;
        logic sf;
        logic zf;
        logic pf;
        logic cf;
    } flags_t;

    function automatic logic is_imm_op(input logic [OPCODE_W-1:0] op);
        case (op)
            MICRO_MOVI, MICRO_LEA, MICRO_ADDI, MICRO_SUBI,
            MICRO_ANDI, MICRO_ORI, MICRO_XORI, MICRO_SLLI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [REG_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(REG_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu.sv
// Full-width integer ALU for the execute stage; immediates arrive already in b.
module alu
    import exec_stage_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_W-1:0]      a,
    input  logic [REG_W-1:0]      b,
    input  logic [BIT_MODE_W-1:0] bit_mode,
    output logic [REG_W-1:0]      y,
    output logic                  known
);

    logic [5:0] cnt;

    always_comb begin
        y     = '0;
        known = 1'b1;
        // Shift count is 5 bits wide except in 64-bit mode.
        cnt   = (bit_mode == BIT_MODE_64) ? b[5:0] : {1'b0, b[4:0]};
        case (opcode)
            MICRO_MOV:               y = a;
            MICRO_MOVI:              y = b;
            MICRO_LEA:               y = a + b;
            MICRO_ADD,  MICRO_ADDI:  y = a + b;
            MICRO_SUB,  MICRO_SUBI:  y = a - b;
            MICRO_AND,  MICRO_ANDI:  y = a & b;
            MICRO_OR,   MICRO_ORI:   y = a | b;
            MICRO_XOR,  MICRO_XORI:  y = a ^ b;
            MICRO_SLLI:              y = a << cnt;
            default:                 known = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_stage_flag_gen.sv
// x86 status flag generation in the active operand width (8/16/32/64).
module flag_gen
    import exec_stage_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_W-1:0]      s,
    input  logic [REG_W-1:0]      t_eff,
    input  logic [REG_W-1:0]      r,
    input  logic [BIT_MODE_W-1:0] bit_mode,
    output flags_t                flags,
    output logic                  flags_we
);

    logic [6:0]       w;
    logic [5:0]       msb;
    logic [REG_W-1:0] mask, sm, tm;
    logic [REG_W:0]   sum;
    logic [5:0]       cnt;
    logic [5:0]       sh_idx;
    logic             sh_cf;

    always_comb begin
        case (bit_mode)
            BIT_MODE_8:  begin w = 7'd8;  msb = 6'd7;  mask = 64'h0000_0000_0000_00FF; end
            BIT_MODE_16: begin w = 7'd16; msb = 6'd15; mask = 64'h0000_0000_0000_FFFF; end
            BIT_MODE_32: begin w = 7'd32; msb = 6'd31; mask = 64'h0000_0000_FFFF_FFFF; end
            default:     begin w = 7'd64; msb = 6'd63; mask = '1; end
        endcase
        sm  = s & mask;
        tm  = t_eff & mask;
        sum = {1'b0, sm} + {1'b0, tm};

        // Last bit shifted out is s[w-count]; modulo-64 subtraction also covers w=64.
        cnt    = (bit_mode == BIT_MODE_64) ? t_eff[5:0] : {1'b0, t_eff[4:0]};
        sh_idx = w[5:0] - cnt;
        sh_cf  = ({1'b0, cnt} <= w) ? s[sh_idx] : 1'b0;

        flags    = '0;
        flags_we = 1'b0;
        flags.zf = ((r & mask) == '0);
        flags.sf = r[msb];
        flags.pf = ~^r[7:0];
        case (opcode)
            MICRO_ADD, MICRO_ADDI: begin
                flags.cf = sum[w];
                flags.of = (s[msb] == t_eff[msb]) && (r[msb] != s[msb]);
                flags_we = 1'b1;
            end
            MICRO_SUB, MICRO_SUBI: begin
                flags.cf = (sm < tm);
                flags.of = (s[msb] != t_eff[msb]) && (r[msb] != s[msb]);
                flags_we = 1'b1;
            end
            MICRO_AND, MICRO_ANDI, MICRO_OR, MICRO_ORI, MICRO_XOR, MICRO_XORI: begin
                flags_we = 1'b1;
            end
            MICRO_SLLI: begin
                if (cnt != 6'd0) begin
                    flags.cf = sh_cf;
                    flags.of = sh_cf ^ r[msb];
                    flags_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Registered execute stage: one micro-op per cycle, result and flags held toward writeback.
module exec_stage
    import exec_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   in_opcode,
    input  logic [REG_W-1:0]      in_s,
    input  logic [REG_W-1:0]      in_t,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [BIT_MODE_W-1:0] in_bit_mode,
    input  logic [RADDR_W-1:0]    in_rd,
    input  logic                  in_wr_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_W-1:0]      out_d,
    output logic [RADDR_W-1:0]    out_rd,
    output logic                  out_wr_en,
    output logic [4:0]            out_flags,
    output logic                  out_flags_we,
    output logic [4:0]            rflags
);

    logic [REG_W-1:0] t_eff, alu_y;
    logic             alu_known;
    flags_t           fg_flags, flags_q, rflags_q;
    logic             fg_we;
    logic             accept, commit;

    assign t_eff = is_imm_op(in_opcode) ? sext_imm(in_imm) : in_t;

    alu u_alu (
        .opcode   (in_opcode),
        .a        (in_s),
        .b        (t_eff),
        .bit_mode (in_bit_mode),
        .y        (alu_y),
        .known    (alu_known)
    );

    flag_gen u_flag_gen (
        .opcode   (in_opcode),
        .s        (in_s),
        .t_eff    (t_eff),
        .r        (alu_y),
        .bit_mode (in_bit_mode),
        .flags    (fg_flags),
        .flags_we (fg_we)
    );

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign commit    = out_valid && out_ready && !flush;
    assign out_flags = flags_q;
    assign rflags    = rflags_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_d        <= '0;
            out_rd       <= '0;
            out_wr_en    <= 1'b0;
            flags_q      <= '0;
            out_flags_we <= 1'b0;
            rflags_q     <= '0;
        end else begin
            if (commit && out_flags_we)
                rflags_q <= flags_q;
            // Flush wins over both the pending commit and any same-cycle accept.
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_d        <= alu_y;
                out_rd       <= in_rd;
                out_wr_en    <= in_wr_en && alu_known;
                flags_q      <= fg_flags;
                out_flags_we <= fg_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed plus randomized bench for exec_stage, checked against a transaction-level flag model.
module tb_exec_stage;
    import exec_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [OPCODE_W-1:0]   in_opcode;
    logic [REG_W-1:0]      in_s;
    logic [REG_W-1:0]      in_t;
    logic [IMM_W-1:0]      in_imm;
    logic [BIT_MODE_W-1:0] in_bit_mode;
    logic [RADDR_W-1:0]    in_rd;
    logic                  in_wr_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_W-1:0]      out_d;
    logic [RADDR_W-1:0]    out_rd;
    logic                  out_wr_en;
    logic [4:0]            out_flags;
    logic                  out_flags_we;
    logic [4:0]            rflags;

    exec_stage dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_s(in_s), .in_t(in_t), .in_imm(in_imm), .in_bit_mode(in_bit_mode),
        .in_rd(in_rd), .in_wr_en(in_wr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .out_flags(out_flags), .out_flags_we(out_flags_we),
        .rflags(rflags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  rd;
        logic        wr;
        logic [4:0]  fl;
        logic        fwe;
    } exp_t;

    exp_t       q[$];
    logic [4:0] m_rflags;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Result of one micro-op from the x86 flag rules, evaluated on plain integers.
    function automatic exp_t model(input logic [4:0] op, input logic [63:0] s, input logic [63:0] t,
                                   input logic [31:0] imm, input logic [1:0] bm,
                                   input logic [3:0] rd, input logic wr);
        exp_t        e;
        int          w;
        int          cnt;
        int          kind;
        logic [63:0] mask, ie, b, d;
        logic [64:0] sum;
        logic        ca, ov, sg_s, sg_b, sg_d;
        w    = 8 << bm;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ie   = {{32{imm[31]}}, imm};
        kind = 0;
        b    = t;
        d    = 64'd0;
        e.wr = wr;
        e.fwe = 1'b1;
        ca = 1'b0;
        ov = 1'b0;
        case (op)
            MICRO_MOV:  begin d = s;      e.fwe = 1'b0; end
            MICRO_MOVI: begin d = ie;     e.fwe = 1'b0; end
            MICRO_LEA:  begin d = s + ie; e.fwe = 1'b0; end
            MICRO_ADD:  kind = 1;
            MICRO_ADDI: begin kind = 1; b = ie; end
            MICRO_SUB:  kind = 2;
            MICRO_SUBI: begin kind = 2; b = ie; end
            MICRO_AND:  d = s & t;
            MICRO_ANDI: d = s & ie;
            MICRO_OR:   d = s | t;
            MICRO_ORI:  d = s | ie;
            MICRO_XOR:  d = s ^ t;
            MICRO_XORI: d = s ^ ie;
            MICRO_SLLI: kind = 3;
            default: begin e.fwe = 1'b0; e.wr = 1'b0; end
        endcase
        sg_s = s[w-1];
        sg_b = b[w-1];
        if (kind == 1) begin
            d   = s + b;
            sum = {1'b0, s & mask} + {1'b0, b & mask};
            ca  = sum[w];
            ov  = (sg_s == sg_b) && (d[w-1] != sg_s);
        end else if (kind == 2) begin
            d  = s - b;
            ca = ((s & mask) < (b & mask));
            ov = (sg_s != sg_b) && (d[w-1] != sg_s);
        end else if (kind == 3) begin
            cnt = (w == 64) ? int'(imm[5:0]) : int'(imm[4:0]);
            d   = s << cnt;
            if (cnt == 0) e.fwe = 1'b0;
            else begin
                ca = (cnt > w) ? 1'b0 : s[w-cnt];
                ov = ca ^ d[w-1];
            end
        end
        sg_d = d[w-1];
        e.d  = d;
        e.rd = rd;
        e.fl = {ov, sg_d, ((d & mask) == 64'd0), ~^d[7:0], ca};
        return e;
    endfunction

    task automatic check_out();
        exp_t h;
        chk("out_valid", out_valid, q.size() != 0);
        chk("rflags", rflags, m_rflags);
        if (q.size() != 0) begin
            h = q[0];
            chk("out_d", out_d, h.d);
            chk("out_rd", out_rd, h.rd);
            chk("out_wr_en", out_wr_en, h.wr);
            chk("out_flags_we", out_flags_we, h.fwe);
            if (h.fwe) chk("out_flags", out_flags, h.fl);
        end
    endtask

    // One clock: drive at negedge, check, advance the model, wait for next negedge.
    task automatic cyc(input bit v, input logic [4:0] op, input logic [63:0] s, input logic [63:0] t,
                       input logic [31:0] imm, input logic [1:0] bm, input logic [3:0] rd,
                       input bit wr, input bit ordy, input bit fl, output bit acc);
        bit   rdy;
        exp_t h;
        in_valid = v; in_opcode = op; in_s = s; in_t = t; in_imm = imm;
        in_bit_mode = bm; in_rd = rd; in_wr_en = wr; out_ready = ordy; flush = fl;
        #1;
        rdy = (q.size() == 0) || ordy;
        chk("in_ready", in_ready, rdy);
        check_out();
        acc = v && rdy && !fl;
        if (fl) q.delete();
        else begin
            if (q.size() != 0 && ordy) begin
                h = q.pop_front();
                if (h.fwe) m_rflags = h.fl;
            end
            if (v && rdy) q.push_back(model(op, s, t, imm, bm, rd, wr));
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] pat[8];
        pat = '{64'h7F, 64'h80, 64'hFF, 64'h7FFF, 64'h8000, 64'h7FFF_FFFF,
                64'h8000_0000, 64'h8000_0000_0000_0000};
        case ($urandom % 4)
            0: return {$urandom, $urandom};
            1: return 64'($urandom % 4);
            2: return pat[$urandom % 8];
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    initial begin
        bit          acc;
        int          idx;
        int          k;
        logic [4:0]  saved;
        logic [4:0]  bp_op[3];
        logic [63:0] bp_s[3];
        logic [63:0] rs, rt;
        logic [31:0] ri;

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_s = '0; in_t = '0; in_imm = '0; in_bit_mode = '0;
        in_rd = '0; in_wr_en = 1'b0;
        m_rflags = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_d", out_d, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_wr_en", out_wr_en, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_flags_we", out_flags_we, 0);
        chk("rst_rflags", rflags, 0);
        chk("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        @(negedge clk);

        // ADDI 8-bit signed overflow
        cyc(1, MICRO_ADDI, 64'h7F, 64'd0, 32'd1, BIT_MODE_8, 4'd1, 1, 1, 0, acc);
        #1;
        chk("addi8_d", {56'd0, out_d[7:0]}, 64'h80);
        chk("addi8_flags", out_flags, 5'b11000);
        cyc(0, MICRO_MOV, 0, 0, 0, BIT_MODE_64, 4'd0, 0, 1, 0, acc);
        chk("addi8_rflags", rflags, 5'b11000);

        // SUB 64-bit equal, SUB 32-bit borrow, then XOR clears CF, MOVI leaves rflags
        cyc(1, MICRO_SUB, 64'd5, 64'd5, 32'd0, BIT_MODE_64, 4'd2, 1, 1, 0, acc);
        #1;
        chk("sub64_flags", out_flags, 5'b00110);
        cyc(1, MICRO_SUB, 64'd0, 64'd1, 32'd0, BIT_MODE_32, 4'd3, 1, 1, 0, acc);
        #1;
        chk("sub32_d", {32'd0, out_d[31:0]}, 64'hFFFF_FFFF);
        chk("sub32_flags", out_flags, 5'b01011);
        cyc(1, MICRO_XOR, 64'hABCD, 64'hABCD, 32'd0, BIT_MODE_16, 4'd4, 1, 1, 0, acc);
        #1;
        chk("xor16_rflags_cf", rflags, 5'b01011);
        chk("xor16_flags", out_flags, 5'b00110);
        cyc(1, MICRO_MOVI, 64'd0, 64'd0, 32'hFFFF_FFFF, BIT_MODE_64, 4'd5, 1, 1, 0, acc);
        #1;
        chk("movi_d", out_d, 64'hFFFF_FFFF_FFFF_FFFF);
        saved = rflags;
        cyc(0, MICRO_MOV, 0, 0, 0, BIT_MODE_64, 4'd0, 0, 1, 0, acc);
        chk("movi_rflags", rflags, saved);

        // Backpressure: three ops, out_ready low for four cycles
        bp_op = '{MICRO_ADD, MICRO_SUBI, MICRO_SLLI};
        bp_s  = '{64'h11, 64'h2222, 64'h8000_0001};
        idx = 0;
        for (k = 0; k < 20 && (idx < 3 || q.size() != 0); k++) begin
            cyc(idx < 3, bp_op[idx % 3], bp_s[idx % 3], 64'h3, 32'd1, BIT_MODE_32,
                4'(idx + 6), 1, !(k >= 1 && k <= 4), 0, acc);
            if (acc) idx++;
        end
        chk("bp_all_issued", idx, 3);
        chk("bp_drained", q.size(), 0);

        // Full throughput
        for (int i = 0; i < 5; i++) begin
            cyc(1, MICRO_ADDI, 64'(i * 3), 64'd0, 32'(i), BIT_MODE_64, 4'(i), 1, 1, 0, acc);
            chk("thru_acc", acc, 1);
        end

        // Flush while a result is held and another is arriving
        cyc(1, MICRO_SUB, 64'd0, 64'd1, 32'd0, BIT_MODE_8, 4'd9, 1, 1, 0, acc);
        saved = m_rflags;
        cyc(1, MICRO_ADD, 64'd1, 64'd2, 32'd0, BIT_MODE_8, 4'd10, 1, 1, 1, acc);
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_rflags", rflags, saved);
        cyc(0, MICRO_MOV, 0, 0, 0, BIT_MODE_64, 4'd0, 0, 1, 0, acc);

        // Asynchronous reset pulse between edges
        cyc(1, MICRO_SUB, 64'd0, 64'd1, 32'd0, BIT_MODE_64, 4'd11, 1, 1, 0, acc);
        cyc(1, MICRO_ADD, 64'd7, 64'd8, 32'd0, BIT_MODE_64, 4'd12, 1, 0, 0, acc);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_rflags", rflags, 0);
        rstn = 1'b1;
        q.delete();
        m_rflags = 5'd0;
        @(negedge clk);
        cyc(1, MICRO_ADD, 64'hFF, 64'd1, 32'd0, BIT_MODE_8, 4'd13, 1, 1, 0, acc);
        #1;
        chk("post_reset_valid", out_valid, 1);
        chk("post_reset_d", out_d, 64'h100);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rs = rnd64();
            rt = ($urandom % 5 == 0) ? rs : rnd64();
            ri = ($urandom % 2 == 0) ? $urandom : ($urandom % 70);
            cyc(($urandom % 5) != 0, 5'($urandom % 16), rs, rt, ri, 2'($urandom % 4),
                4'($urandom), 1'($urandom), ($urandom % 10) < 7, ($urandom % 32) == 0, acc);
        end
        repeat (2) cyc(0, MICRO_MOV, 0, 0, 0, BIT_MODE_64, 4'd0, 0, 1, 0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
